// File: rtl/prod_accum_pkg.sv
// Shared defaults, FSM encoding and result record for the product accumulator stage.
package prod_accum_pkg;

    localparam int PW_DEF = 64;
    localparam int AW_DEF = 80;
    localparam int CW_DEF = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    typedef struct packed {
        logic [AW_DEF-1:0] sum;
        logic [CW_DEF-1:0] count;
        logic              ovf;
    } res_rec_t;

endpackage

// File: rtl/prod_accum_stage_acc_out_reg.sv
// One-entry result holding register with a valid/ready output handshake.
module acc_out_reg
    import prod_accum_pkg::*;
#(
    parameter type rec_t = res_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  rec_t i_rec,
    input  logic i_ready,
    output logic o_valid,
    output rec_t o_rec,
    output logic o_full
);

    logic r_valid;
    rec_t r_rec;

    // A load wins over a drain at the same edge, so back-to-back results never bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rec   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_rec   <= i_rec;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_rec   = r_rec;
    assign o_full  = r_valid && !i_ready;

endmodule

// File: rtl/prod_accum_stage.sv
// Grouped multiply-accumulate back end: sums tagged product beats and emits one result per group.
module prod_accum_stage
    import prod_accum_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prod_valid,
    output logic          prod_ready,
    input  logic [PW-1:0] prod,
    input  logic          prod_last,
    input  logic          clear,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_sum,
    output logic [CW-1:0] res_count,
    output logic          res_ovf
);

    typedef struct packed {
        logic [AW-1:0] sum;
        logic [CW-1:0] count;
        logic          ovf;
    } rec_t;

    logic [0:0]    r_state;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;

    logic          w_take;
    logic          w_load;
    logic          w_full;
    logic [AW-1:0] w_base_acc;
    logic [CW-1:0] w_base_cnt;
    logic          w_base_ovf;
    logic [AW-1:0] w_sum;
    logic          w_carry;
    logic [CW-1:0] w_cnt_next;
    logic          w_ovf_next;
    rec_t          w_rec;
    rec_t          w_out_rec;

    assign prod_ready = rst_n && !w_full;
    assign w_take     = prod_valid && prod_ready;
    assign w_load     = w_take && prod_last && !clear;

    // In IDLE the beat starts a fresh group, so the partial state is treated as zero.
    always_comb begin
        w_base_acc = '0;
        w_base_cnt = '0;
        w_base_ovf = 1'b0;
        if (r_state == ST_ACCUM) begin
            w_base_acc = r_acc;
            w_base_cnt = r_cnt;
            w_base_ovf = r_ovf;
        end
    end

    assign {w_carry, w_sum} = {1'b0, w_base_acc} + {1'b0, AW'(prod)};
    assign w_cnt_next       = (&w_base_cnt) ? w_base_cnt : w_base_cnt + CW'(1);
    assign w_ovf_next       = w_base_ovf | w_carry;

    always_comb begin
        w_rec       = '0;
        w_rec.sum   = w_sum;
        w_rec.count = w_cnt_next;
        w_rec.ovf   = w_ovf_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_take) begin
            if (prod_last) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_state <= ST_ACCUM;
                r_acc   <= w_sum;
                r_cnt   <= w_cnt_next;
                r_ovf   <= w_ovf_next;
            end
        end
    end

    acc_out_reg #(
        .rec_t(rec_t)
    ) u_out (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_rec  (w_rec),
        .i_ready(res_ready),
        .o_valid(res_valid),
        .o_rec  (w_out_rec),
        .o_full (w_full)
    );

    assign res_sum   = w_out_rec.sum;
    assign res_count = w_out_rec.count;
    assign res_ovf   = w_out_rec.ovf;

endmodule

// File: tb/tb_prod_accum_stage.sv
// Directed bench: two stage instances (AW=65/CW=16 and AW=80/CW=2) share one stimulus stream.
module tb_prod_accum_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prod_valid;
    logic [63:0] prod;
    logic        prod_last;
    logic        clear;
    logic        res_ready;

    logic        prod_ready_a, res_valid_a, res_ovf_a;
    logic [64:0] res_sum_a;
    logic [15:0] res_count_a;
    logic        prod_ready_b, res_valid_b, res_ovf_b;
    logic [79:0] res_sum_b;
    logic [1:0]  res_count_b;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [64:0] sum_a;
        logic [79:0] sum_b;
        logic [15:0] cnt_a;
        logic [1:0]  cnt_b;
        logic        ovf_a;
        logic        ovf_b;
    } exp_t;

    exp_t q[$];
    logic [127:0] m_total = '0;
    int           m_n = 0;

    always #5 clk = ~clk;

    prod_accum_stage #(.PW(64), .AW(65), .CW(16)) u_a (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(prod_ready_a),
        .prod(prod), .prod_last(prod_last), .clear(clear), .res_valid(res_valid_a),
        .res_ready(res_ready), .res_sum(res_sum_a), .res_count(res_count_a), .res_ovf(res_ovf_a)
    );

    prod_accum_stage #(.PW(64), .AW(80), .CW(2)) u_b (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(prod_ready_b),
        .prod(prod), .prod_last(prod_last), .clear(clear), .res_valid(res_valid_b),
        .res_ready(res_ready), .res_sum(res_sum_b), .res_count(res_count_b), .res_ovf(res_ovf_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_total = '0;
        m_n     = 0;
    endtask

    // Expected values come from the exact group total, then reduced to each instance's widths.
    task automatic model_accept(input logic [63:0] p, input logic last, input logic clr);
        exp_t e;
        if (clr) begin
            model_reset();
        end else begin
            m_total = m_total + {64'd0, p};
            m_n++;
            if (last) begin
                e.sum_a = m_total[64:0];
                e.sum_b = m_total[79:0];
                e.ovf_a = |m_total[127:65];
                e.ovf_b = |m_total[127:80];
                e.cnt_a = (m_n > 65535) ? 16'hFFFF : 16'(m_n);
                e.cnt_b = (m_n > 3) ? 2'd3 : 2'(m_n);
                q.push_back(e);
                model_reset();
            end
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic send(input logic [63:0] p, input logic last, input logic clr);
        int k = 0;
        prod_valid = 1'b1;
        prod       = p;
        prod_last  = last;
        clear      = clr;
        #1;
        while (!(prod_ready_a && prod_ready_b) && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("prod_ready_wait", {127'd0, prod_ready_a && prod_ready_b}, 128'd1);
        if (prod_ready_a && prod_ready_b) begin
            @(posedge clk);
            model_accept(p, last, clr);
            @(negedge clk);
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        clear      = 1'b0;
    endtask

    // Result monitor: a new result is visible when res_valid rises or is reloaded across a handshake.
    logic r_hs = 1'b0;
    logic r_prev_valid = 1'b0;

    always @(posedge clk) r_hs <= rst_n && res_valid_a && res_ready;

    always @(negedge clk) begin
        exp_t e;
        if (res_valid_a && (!r_prev_valid || r_hs)) begin
            chk("sb_nonempty", {127'd0, q.size() != 0}, 128'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                $display("result: sum_a=%0h cnt_a=%0d ovf_a=%0b sum_b=%0h cnt_b=%0d ovf_b=%0b",
                         res_sum_a, res_count_a, res_ovf_a, res_sum_b, res_count_b, res_ovf_b);
                chk("res_valid_b", {127'd0, res_valid_b}, 128'd1);
                chk("res_sum_a",   {63'd0, res_sum_a},   {63'd0, e.sum_a});
                chk("res_sum_b",   {48'd0, res_sum_b},   {48'd0, e.sum_b});
                chk("res_count_a", {112'd0, res_count_a}, {112'd0, e.cnt_a});
                chk("res_count_b", {126'd0, res_count_b}, {126'd0, e.cnt_b});
                chk("res_ovf_a",   {127'd0, res_ovf_a},   {127'd0, e.ovf_a});
                chk("res_ovf_b",   {127'd0, res_ovf_b},   {127'd0, e.ovf_b});
            end
        end
        r_prev_valid = res_valid_a;
    end

    initial begin
        // Reset held with a beat offered.
        rst_n      = 1'b0;
        prod_valid = 1'b1;
        prod       = 64'h123;
        prod_last  = 1'b1;
        clear      = 1'b0;
        res_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_prod_ready", {127'd0, prod_ready_a}, 128'd0);
        chk("rst_res_valid",  {127'd0, res_valid_a},  128'd0);
        chk("rst_res_sum",    {63'd0, res_sum_a},     128'd0);
        chk("rst_res_count",  {112'd0, res_count_a},  128'd0);
        chk("rst_res_ovf",    {127'd0, res_ovf_a},    128'd0);
        rst_n      = 1'b1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        #1;
        chk("post_rst_prod_ready", {127'd0, prod_ready_a}, 128'd1);
        repeat (3) @(negedge clk);

        // Three-beat group, downstream always ready.
        send(64'h10, 1'b0, 1'b0);
        send(64'h20, 1'b0, 1'b0);
        send(64'h30, 1'b1, 1'b0);
        chk("grp3_valid_high", {127'd0, res_valid_a}, 128'd1);
        @(negedge clk);
        chk("grp3_valid_fall", {127'd0, res_valid_a}, 128'd0);

        // Carry out of 65 bits; the next group starts with overflow clear.
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send(64'h2, 1'b1, 1'b0);
        send(64'h1, 1'b1, 1'b0);
        @(negedge clk);

        // Backpressure with a pending result, then same-cycle drain and reload.
        res_ready = 1'b0;
        send(64'h5, 1'b1, 1'b0);
        prod_valid = 1'b1;
        prod       = 64'h7;
        prod_last  = 1'b1;
        #1;
        chk("bp_prod_ready0", {127'd0, prod_ready_a}, 128'd0);
        chk("bp_sum_hold0",   {63'd0, res_sum_a},     128'h5);
        @(negedge clk);
        #1;
        chk("bp_prod_ready1", {127'd0, prod_ready_a}, 128'd0);
        chk("bp_sum_hold1",   {63'd0, res_sum_a},     128'h5);
        chk("bp_valid_hold",  {127'd0, res_valid_a},  128'd1);
        res_ready = 1'b1;
        #1;
        chk("bp_drain_ready", {127'd0, prod_ready_a}, 128'd1);
        send(64'h7, 1'b1, 1'b0);
        chk("bp_reload_sum",   {63'd0, res_sum_a},    128'h7);
        chk("bp_reload_valid", {127'd0, res_valid_a}, 128'd1);
        @(negedge clk);

        // clear discards the partial group and a last beat taken with it.
        send(64'h5, 1'b0, 1'b0);
        send(64'h7, 1'b0, 1'b0);
        send(64'h9, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        send(64'h4, 1'b1, 1'b0);
        @(negedge clk);

        // Reset mid-group aborts it.
        send(64'h3, 1'b0, 1'b0);
        send(64'h3, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(64'h8, 1'b1, 1'b0);
        @(negedge clk);

        // Five beats: the 2-bit counter saturates at 3, the 16-bit one reads 5.
        for (int i = 0; i < 5; i++) send(64'h1, (i == 4), 1'b0);
        repeat (4) @(negedge clk);

        chk("sb_drained", {96'd0, 32'(q.size())}, 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
